// File: rtl/dpc_io_pkg.sv
// Shared DekatronPC I/O definitions: ASCII control codes and the
// stdout_buffer downstream FSM state type.
package dpc_io_pkg;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   typedef enum logic [1:0] {
      D_IDLE,
      D_REQ,
      D_RELEASE
   } stdout_dstate_t;

endpackage

// File: rtl/stdout_buffer_if.sv
// Bundle of the stdout_buffer handshake, data and status signals.
// Handshakes: CoutIn is a level request held with DataIn stable until the
// one-cycle CioAcqOut pulse; CoutOut is a level request with DataOut valid
// while high, answered by the (asynchronous) CoutAckIn level rising, and the
// next request waits for CoutAckIn to fall again.
interface stdout_buffer_if
   import dpc_io_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int DATA_WIDTH = 8
);
   localparam int LEVEL_W = $clog2(DEPTH + 1);

   logic                  Flush;
   logic                  CoutIn;
   logic [DATA_WIDTH-1:0] DataIn;
   logic                  CioAcqOut;
   logic                  CoutOut;
   logic [DATA_WIDTH-1:0] DataOut;
   logic                  CoutAckIn;
   logic [LEVEL_W-1:0]    Level;
   logic                  Full;
   stdout_dstate_t        DState;

   modport slave (
      input  Flush, CoutIn, DataIn, CoutAckIn,
      output CioAcqOut, CoutOut, DataOut, Level, Full, DState
   );

   modport master (
      output Flush, CoutIn, DataIn, CoutAckIn,
      input  CioAcqOut, CoutOut, DataOut, Level, Full, DState
   );

endinterface

// File: rtl/byte_fifo.sv
// Plain byte FIFO: RAM array with extra-MSB read/write pointers, occupancy,
// full/empty flags and synchronous flush. No handshake logic lives here.
module byte_fifo #(
   parameter int DEPTH      = 16,
   parameter int DATA_WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic                         push,
   input  logic [DATA_WIDTH-1:0]        wdata,
   input  logic                         pop,
   output logic [DATA_WIDTH-1:0]        rdata,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         full,
   output logic                         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW:0]           wr_ptr;
   logic [AW:0]           rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   // Storage array; contents need no reset because empty masks them.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   // Pointer update; flush returns both pointers to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   assign rdata = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign level = wr_ptr - rd_ptr;

   // The downstream FSM only pops from D_REQ, which is entered on non-empty.
   pop_not_empty_a: assert property (@(posedge clk) disable iff (!rst_n) pop |-> !empty);

endmodule

// File: rtl/stdout_buffer.sv
// stdout_buffer: decouples DekatronPC character output from the slow consul
// teletype. Upstream accept latch, ack synchroniser and the downstream
// request FSM live here; storage is in byte_fifo.
// Build option STDOUT_BUFFER_CRLF_EN: store an accepted LF as CR then LF.
module stdout_buffer
   import dpc_io_pkg::*;
#(
   parameter int DEPTH       = 16,
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic           Clk,
   input  logic           Rst_n,
   stdout_buffer_if.slave bus
);
   localparam int LEVEL_W = $clog2(DEPTH + 1);

   logic [SYNC_STAGES-1:0] ack_sync;
   logic                   ack_s;
   logic                   ack_d;
   logic                   ack_rise;
   logic                   acc_latch;
   logic                   acq_q;
   logic                   accept;
   logic                   fifo_push;
   logic                   fifo_pop;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [DATA_WIDTH-1:0]  fifo_wdata;
   logic [DATA_WIDTH-1:0]  fifo_rdata;
   logic [LEVEL_W-1:0]     fifo_level;
   stdout_dstate_t         state_q;
   stdout_dstate_t         state_d;
   logic                   cout;

   // Bring the consul acknowledge into Clk and keep last value for edge detect.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         ack_sync <= '0;
         ack_d    <= 1'b0;
      end else begin
         ack_sync <= SYNC_STAGES'({ack_sync, bus.CoutAckIn});
         ack_d    <= ack_s;
      end
   end

   assign ack_s    = ack_sync[SYNC_STAGES-1];
   assign ack_rise = ack_s && !ack_d;

`ifdef STDOUT_BUFFER_CRLF_EN
   localparam logic [LEVEL_W-1:0] LF_ROOM = LEVEL_W'(DEPTH - 2);

   logic lf_pending;
   logic is_lf;

   assign is_lf      = (bus.DataIn == DATA_WIDTH'(ASCII_LF));
   assign accept     = bus.CoutIn && !acc_latch && !lf_pending && !bus.Flush &&
                       (is_lf ? (fifo_level <= LF_ROOM) : !fifo_full);
   assign fifo_push  = accept || lf_pending;
   assign fifo_wdata = lf_pending ? DATA_WIDTH'(ASCII_LF) :
                       (is_lf ? DATA_WIDTH'(ASCII_CR) : bus.DataIn);

   // An accepted LF writes CR first, then the LF on the following edge.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n)         lf_pending <= 1'b0;
      else if (bus.Flush) lf_pending <= 1'b0;
      else                lf_pending <= accept && is_lf;
   end
`else
   assign accept     = bus.CoutIn && !acc_latch && !bus.Flush && !fifo_full;
   assign fifo_push  = accept;
   assign fifo_wdata = bus.DataIn;
`endif

   // One push per CoutIn assertion; the latch is released when CoutIn drops.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         acc_latch <= 1'b0;
         acq_q     <= 1'b0;
      end else begin
         acq_q <= accept;
         if (accept)           acc_latch <= 1'b1;
         else if (!bus.CoutIn) acc_latch <= 1'b0;
      end
   end

   // Downstream FSM state register.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) state_q <= D_IDLE;
      else        state_q <= state_d;
   end

   // Downstream FSM: request, pop on ack rise, wait for ack fall.
   always_comb begin
      state_d  = state_q;
      cout     = 1'b0;
      fifo_pop = 1'b0;
      case (state_q)
         D_IDLE: begin
            if (!fifo_empty) state_d = D_REQ;
         end
         D_REQ: begin
            cout = 1'b1;
            if (ack_rise) begin
               fifo_pop = 1'b1;
               state_d  = D_RELEASE;
            end
         end
         D_RELEASE: begin
            if (!ack_s) state_d = D_IDLE;
         end
         default: state_d = D_IDLE;
      endcase
      if (bus.Flush) begin
         state_d  = D_IDLE;
         fifo_pop = 1'b0;
      end
   end

   byte_fifo #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_fifo (
      .clk   (Clk),
      .rst_n (Rst_n),
      .flush (bus.Flush),
      .push  (fifo_push),
      .wdata (fifo_wdata),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .level (fifo_level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign bus.CioAcqOut = acq_q;
   assign bus.CoutOut   = cout;
   assign bus.DataOut   = cout ? fifo_rdata : '0;
   assign bus.Level     = fifo_level;
   assign bus.Full      = fifo_full;
   assign bus.DState    = state_q;

endmodule
